// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Loader protocol states.
  typedef enum logic [2:0] {
    SEND_HELLO = 3'd0,
    RECV_SIZE  = 3'd1,
    RECV_PROG  = 3'd2,
    SEND_ACK   = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [7:0] HELLO_BYTE = 8'h99;
  localparam logic [7:0] ACK_BYTE   = 8'haa;
  localparam int         SIZE_BYTES = 4;

  // A program size must be a whole number of 32-bit words.
  function automatic logic size_misaligned(input logic [31:0] nbytes);
    return nbytes[1:0] != 2'b00;
  endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Little-endian 4-byte shift register with position counter.
//               word_valid pulses for one cycle after every 4th byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int CW = $clog2(SIZE_BYTES);

  logic [CW-1:0] count;

  // Shift each byte in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      word       <= '0;
      count      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        word <= {byte_in, word[31:8]};
        if (count == CW'(SIZE_BYTES - 1)) begin
          count      <= '0;
          word_valid <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule : byte_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : UART boot loader. Sends 0x99, receives a 4-byte little-endian
//               byte count and the program, writes it word by word into
//               instruction memory, then sends 0xAA and raises loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  rx_ready,
  input  logic [7:0]            rdata,
  input  logic                  ferr,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            sdata,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wd,
  output logic                  loaded,
  output logic                  error
);

  // Word index carries one extra bit so a MAX_WORDS program cannot overflow.
  localparam int         IW        = ADDR_WIDTH + 1;
  localparam logic [63:0] MAX_BYTES = 64'(MAX_WORDS) * 64'd4;

  state_t          state, state_next;
  logic [1:0]      rst_sync;
  logic [IW-1:0]   word_index;
  logic [IW-1:0]   size_words;
  logic [31:0]     word;
  logic            word_valid;
  logic            byte_valid;
  logic            tx_start_next;
  logic [7:0]      sdata_next;
  logic            load_size;
  logic            bump_index;

  // Bytes are only consumed while receiving; framing-error bytes are dropped.
  assign byte_valid = rx_ready && !ferr && (state == RECV_SIZE || state == RECV_PROG);

  byte_assembler u_assembler (
    .clock      (clock),
    .resetn     (resetn),
    .byte_valid (byte_valid),
    .byte_in    (rdata),
    .word       (word),
    .word_valid (word_valid)
  );

  // Delay the effect of reset release by two edges so the handshake starts cleanly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  // State register and registered transmit request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= SEND_HELLO;
      tx_start <= 1'b0;
      sdata    <= 8'h00;
    end else begin
      state    <= state_next;
      tx_start <= tx_start_next;
      sdata    <= sdata_next;
    end
  end

  // Program length (in words) and the write pointer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      size_words <= '0;
      word_index <= '0;
    end else if (load_size) begin
      size_words <= word[IW+1:2];
      word_index <= '0;
    end else if (bump_index) begin
      word_index <= word_index + 1'b1;
    end
  end

  // Next-state and transmit decisions.
  always_comb begin
    state_next    = state;
    tx_start_next = 1'b0;
    sdata_next    = sdata;
    load_size     = 1'b0;
    bump_index    = 1'b0;
    case (state)
      SEND_HELLO: begin
        if (rst_sync[1] && !tx_busy && !tx_start) begin
          tx_start_next = 1'b1;
          sdata_next    = HELLO_BYTE;
          state_next    = RECV_SIZE;
        end
      end
      RECV_SIZE: begin
        if (rx_ready && ferr) begin
          state_next = ERROR;
        end else if (word_valid) begin
          if (word == 32'd0) begin
            state_next = SEND_ACK;
          end else if (size_misaligned(word) || ({32'd0, word} > MAX_BYTES)) begin
            state_next = ERROR;
          end else begin
            load_size  = 1'b1;
            state_next = RECV_PROG;
          end
        end
      end
      RECV_PROG: begin
        if (word_valid) begin
          bump_index = 1'b1;
          if (word_index == size_words - 1'b1) state_next = SEND_ACK;
        end
        if (rx_ready && ferr) state_next = ERROR;
      end
      SEND_ACK: begin
        if (!tx_busy && !tx_start) begin
          tx_start_next = 1'b1;
          sdata_next    = ACK_BYTE;
          state_next    = DONE;
        end
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = SEND_HELLO;
    endcase
  end

  // The write strobe follows the assembler's completion pulse directly.
  assign imem_we   = (state == RECV_PROG) && word_valid;
  assign imem_addr = word_index[ADDR_WIDTH-1:0];
  assign imem_wd   = word;
  assign loaded    = (state == DONE);
  assign error     = (state == ERROR);

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int AW = 4;
  localparam int MW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    rdata = 8'h00;
  logic          ferr = 1'b0;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    sdata;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          loaded;
  logic          error;

  int checks = 0;
  int errors = 0;

  logic busy_force = 1'b0;
  int   busy_cnt = 0;
  int   tx_viol = 0;
  logic tx_prev = 1'b0;

  logic [7:0]    tx_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rx_ready  (rx_ready),
    .rdata     (rdata),
    .ferr      (ferr),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .sdata     (sdata),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .loaded    (loaded),
    .error     (error)
  );

  always #5 clock = ~clock;

  assign tx_busy = busy_force || (busy_cnt != 0);

  // UART transmitter model plus capture of every write and transmitted byte.
  always @(negedge clock) begin
    if (!resetn) begin
      busy_cnt = 0;
      tx_prev  = 1'b0;
    end else begin
      if (tx_start && (tx_busy || tx_prev)) tx_viol++;
      tx_prev = tx_start;
      if (tx_start) begin
        tx_q.push_back(sdata);
        busy_cnt = 8;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wd);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    wa_q.delete();
    wd_q.delete();
    tx_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_ready = 1'b1;
    rdata    = b;
    ferr     = fe;
    tick();
    rx_ready = 1'b0;
    ferr     = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) tick();
  endtask

  // Reset, release, and wait for the hello byte; callers check the result.
  task automatic start_session();
    resetn = 1'b0;
    rx_ready = 1'b0;
    ferr = 1'b0;
    repeat (3) tick();
    clear_logs();
    resetn = 1'b1;
    wait_tx(1, 50);
    repeat (12) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rx_ready = 1'b1;
    rdata = 8'h5a;
    repeat (3) tick();
    rx_ready = 1'b0;
    checks++;
    if ({tx_start, sdata, imem_we, imem_addr, imem_wd, loaded, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tx_start=%b sdata=%h we=%b addr=%h wd=%h loaded=%b error=%b, expected all 0",
               tx_start, sdata, imem_we, imem_addr, imem_wd, loaded, error);
    end
  endtask

  task automatic test_hello();
    int lat;
    resetn = 1'b0;
    repeat (3) tick();
    clear_logs();
    resetn = 1'b1;
    lat = 0;
    while (tx_q.size() == 0 && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (tx_q.size() == 0 || lat < 2) begin
      errors++;
      $display("FAIL hello_latency: got %0d edges (seen %0d bytes), expected >= 2 edges and one byte", lat, tx_q.size());
    end
    checks++;
    if (tx_q.size() == 0 || tx_q[0] !== 8'h99) begin
      errors++;
      $display("FAIL hello_byte: got %0d bytes, first %h, expected 99", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
    end
    repeat (30) tick();
    checks++;
    if (tx_q.size() != 1) begin
      errors++;
      $display("FAIL hello_single: got %0d tx_start pulses, expected 1", tx_q.size());
    end
  endtask

  task automatic test_load();
    logic [31:0] exp_w [3];
    exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    start_session();
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h99) begin
      errors++;
      $display("FAIL load_hello: got %0d bytes, expected one 99", tx_q.size());
    end
    send_byte(8'h0C, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (loaded !== 1'b0 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL load_after_size: got loaded=%b writes=%0d, expected 0 and 0", loaded, wa_q.size());
    end
    for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0);
    wait_tx(2, 60);
    checks++;
    if (wa_q.size() != 3) begin
      errors++;
      $display("FAIL load_write_count: got %0d, expected 3", wa_q.size());
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL load_write%0d: got addr %h data %h, expected addr %h data %h", i, wa_q[i], wd_q[i], AW'(i), exp_w[i]);
      end
    end
    checks++;
    if (tx_q.size() != 2 || tx_q[1] !== 8'haa || loaded !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL load_ack: got %0d bytes loaded=%b error=%b, expected 2 bytes ending aa, loaded=1 error=0",
               tx_q.size(), loaded, error);
    end
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    checks++;
    if (wa_q.size() != 3 || tx_q.size() != 2 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL done_quiet: got writes=%0d tx=%0d loaded=%b, expected 3, 2, 1", wa_q.size(), tx_q.size(), loaded);
    end
    checks++;
    if (tx_viol != 0) begin
      errors++;
      $display("FAIL load_tx_protocol: got %0d violations, expected 0", tx_viol);
    end
  endtask

  task automatic test_max_size();
    start_session();
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0);
    wait_tx(2, 60);
    checks++;
    if (wa_q.size() != 4 || wa_q[3] !== 4'd3 || wd_q[3] !== 32'h2F2E2D2C) begin
      errors++;
      $display("FAIL max_size_writes: got %0d writes, last addr %h data %h, expected 4, 3, 2f2e2d2c",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 4'hx, (wd_q.size() > 0) ? wd_q[wd_q.size()-1] : 32'hx);
    end
    checks++;
    if (loaded !== 1'b1 || tx_q.size() != 2) begin
      errors++;
      $display("FAIL max_size_ack: got loaded=%b tx=%0d, expected 1, 2", loaded, tx_q.size());
    end
  endtask

  task automatic test_oversize();
    start_session();
    send_byte(8'h14, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (20) tick();
    checks++;
    if (error !== 1'b1 || loaded !== 1'b0 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL oversize: got error=%b loaded=%b tx=%0d, expected 1, 0, 1", error, loaded, tx_q.size());
    end
  endtask

  task automatic test_zero_size();
    start_session();
    busy_force = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    repeat (10) tick();
    checks++;
    if (tx_q.size() != 1 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_hold: got tx=%0d loaded=%b, expected 1, 0", tx_q.size(), loaded);
    end
    busy_force = 1'b0;
    tick();
    checks++;
    if (tx_q.size() != 2 || tx_q[1] !== 8'haa || loaded !== 1'b1 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL zero_ack: got tx=%0d loaded=%b writes=%0d, expected 2 ending aa, 1, 0",
               tx_q.size(), loaded, wa_q.size());
    end
  endtask

  task automatic test_bad_size();
    start_session();
    send_byte(8'h06, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    repeat (20) tick();
    checks++;
    if (error !== 1'b1 || loaded !== 1'b0 || tx_q.size() != 1 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL bad_size: got error=%b loaded=%b tx=%0d writes=%0d, expected 1, 0, 1, 0",
               error, loaded, tx_q.size(), wa_q.size());
    end
  endtask

  task automatic test_ferr();
    start_session();
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    repeat (10) tick();
    checks++;
    if (wa_q.size() != 1 || wd_q[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL ferr_writes: got %0d writes, first %h, expected 1 write of 44332211",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
    checks++;
    if (error !== 1'b1 || loaded !== 1'b0 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL ferr_state: got error=%b loaded=%b tx=%0d, expected 1, 0, 1", error, loaded, tx_q.size());
    end
  endtask

  task automatic test_busy_delay();
    resetn = 1'b0;
    busy_force = 1'b1;
    repeat (3) tick();
    clear_logs();
    resetn = 1'b1;
    repeat (46) tick();
    send_byte(8'hFF, 1'b0);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL busy_hold: got %0d tx_start pulses while busy, expected 0", tx_q.size());
    end
    busy_force = 1'b0;
    tick();
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h99) begin
      errors++;
      $display("FAIL busy_release: got %0d bytes one cycle after busy fell, expected one 99", tx_q.size());
    end
    repeat (12) tick();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    wait_tx(2, 40);
    checks++;
    if (loaded !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL hello_discard: got loaded=%b error=%b, expected 1, 0", loaded, error);
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] exp_w [3];
    exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    start_session();
    send_byte(8'h0C, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    resetn = 1'b0;
    #1;
    checks++;
    if ({tx_start, sdata, imem_we, imem_addr, imem_wd, loaded, error} !== '0) begin
      errors++;
      $display("FAIL midload_reset_outputs: got sdata=%h addr=%h wd=%h loaded=%b error=%b, expected all 0",
               sdata, imem_addr, imem_wd, loaded, error);
    end
    repeat (3) tick();
    clear_logs();
    resetn = 1'b1;
    wait_tx(1, 50);
    repeat (12) tick();
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h99 || wa_q.size() != 0) begin
      errors++;
      $display("FAIL midload_rehello: got tx=%0d writes=%0d, expected one 99 and no writes", tx_q.size(), wa_q.size());
    end
    send_byte(8'h0C, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b0);
    wait_tx(2, 60);
    checks++;
    if (wa_q.size() != 3 || loaded !== 1'b1) begin
      errors++;
      $display("FAIL midload_reload: got writes=%0d loaded=%b, expected 3, 1", wa_q.size(), loaded);
    end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL midload_write%0d: got addr %h data %h, expected addr %h data %h", i, wa_q[i], wd_q[i], AW'(i), exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_load();
    test_max_size();
    test_oversize();
    test_zero_size();
    test_bad_size();
    test_ferr();
    test_busy_delay();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule : tb_program_loader
`default_nettype wire
